// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int FB_DEPTH = 4;
    localparam int PC_W     = 64;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fb_ram.sv
// Small register array for the fetch buffer.
// Writes on the rising edge; reads are combinational. There is no reset.
module fb_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and decode, with valid/ready on
// both sides and a branch-redirect flush that discards every buffered entry.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int N     = PC_W,
    parameter int DEPTH = FB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_F,
    input  logic [N-1:0]             pc_F,
    input  logic [INSTR_W-1:0]       instr_F,
    input  logic                     flush_F,
    output logic                     ready_F,
    output logic                     valid_D,
    output logic [N-1:0]             pc_D,
    output logic [INSTR_W-1:0]       instr_D,
    input  logic                     ready_D,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = N + INSTR_W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_next;
    occ_state_t    occ_state;

    logic          push;
    logic          pop;
    logic [EW-1:0] head_entry;

    // Occupancy is a pure decode of the registered count, so the handshake
    // outputs never depend combinationally on the other side's inputs.
    always_comb begin
        occ_state = OCC_PARTIAL;
        if (count_q == '0) begin
            occ_state = OCC_EMPTY;
        end else if (count_q == FULL_COUNT) begin
            occ_state = OCC_FULL;
        end
    end

    assign ready_F = (occ_state != OCC_FULL);
    assign valid_D = (occ_state != OCC_EMPTY);
    assign push    = valid_F & ready_F & ~flush_F;
    assign pop     = valid_D & ready_D & ~flush_F;

    always_comb begin
        count_next  = count_q;
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        if (flush_F) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_q + 1'b1;
                2'b01:   count_next = count_q - 1'b1;
                default: count_next = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            count_q <= count_next;
            rd_ptr  <= rd_ptr_next;
            wr_ptr  <= wr_ptr_next;
        end
    end

    fb_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({pc_F, instr_F}),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Storage contents are undefined after reset, so mask the head when empty.
    assign pc_D    = valid_D ? head_entry[EW-1:INSTR_W] : '0;
    assign instr_D = valid_D ? head_entry[INSTR_W-1:0]  : '0;
    assign count   = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: table-driven vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_buffer;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          valid_F;
    logic [N-1:0]  pc_F;
    logic [31:0]   instr_F;
    logic          flush_F;
    logic          ready_F;
    logic          valid_D;
    logic [N-1:0]  pc_D;
    logic [31:0]   instr_D;
    logic          ready_D;
    logic [2:0]    count;

    fetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_F (valid_F),
        .pc_F    (pc_F),
        .instr_F (instr_F),
        .flush_F (flush_F),
        .ready_F (ready_F),
        .valid_D (valid_D),
        .pc_D    (pc_D),
        .instr_D (instr_D),
        .ready_D (ready_D),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } ent_t;

    typedef struct {
        logic         vf;
        logic [N-1:0] pc;
        logic         fl;
        logic         rd;
        int           exp_count;
        logic         exp_valid;
        logic         exp_ready;
        logic [N-1:0] exp_pc;
    } vec_t;

    ent_t         model_q[$];
    logic [N-1:0] seen_pc[$];
    int           total = 0;
    int           bad   = 0;

    function automatic logic [31:0] instr_of(input logic [N-1:0] pc);
        return pc[31:0] ^ 32'h1300_0013;
    endfunction

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against what the reference queue implies.
    task automatic checkOutput(input string tag);
        logic [N-1:0] e_pc;
        logic [31:0]  e_instr;
        e_pc    = '0;
        e_instr = '0;
        if (model_q.size() > 0) begin
            e_pc    = model_q[0].pc;
            e_instr = model_q[0].instr;
        end
        cmp({tag, ".count"},   N'(count),   N'(model_q.size()));
        cmp({tag, ".valid_D"}, N'(valid_D), N'(model_q.size() > 0));
        cmp({tag, ".ready_F"}, N'(ready_F), N'(model_q.size() < DEPTH));
        cmp({tag, ".pc_D"},    pc_D,        e_pc);
        cmp({tag, ".instr_D"}, N'(instr_D), N'(e_instr));
    endtask

    // One full clock cycle: drive, check mid-cycle, clock, update model.
    // Entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic vf, input logic [N-1:0] pc,
                                 input logic [31:0] instr, input logic fl,
                                 input logic rd, input string tag);
        logic do_push;
        logic do_pop;
        ent_t e;
        valid_F = vf;
        pc_F    = pc;
        instr_F = instr;
        flush_F = fl;
        ready_D = rd;
        #3;
        checkOutput(tag);
        do_push = vf && (model_q.size() < DEPTH) && !fl;
        do_pop  = rd && (model_q.size() > 0) && !fl;
        if (do_pop) seen_pc.push_back(pc_D);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc    = pc;
                e.instr = instr;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, tag);
    endtask

    vec_t vecs[15];

    initial begin
        reset   = 1'b1;
        valid_F = 1'b0;
        pc_F    = '0;
        instr_F = '0;
        flush_F = 1'b0;
        ready_D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then idle.
        cmp("reset.count",   N'(count),   '0);
        cmp("reset.valid_D", N'(valid_D), '0);
        cmp("reset.ready_F", N'(ready_F), N'(1));
        cmp("reset.pc_D",    pc_D,        '0);
        idle(5, "idle");

        // Fill to full, overflow push, drain, then flush with push+pop.
        vecs[0]  = '{1'b1, 64'h0,   1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h0};
        vecs[1]  = '{1'b1, 64'h4,   1'b0, 1'b0, 2, 1'b1, 1'b1, 64'h0};
        vecs[2]  = '{1'b1, 64'h8,   1'b0, 1'b0, 3, 1'b1, 1'b1, 64'h0};
        vecs[3]  = '{1'b1, 64'hC,   1'b0, 1'b0, 4, 1'b1, 1'b0, 64'h0};
        vecs[4]  = '{1'b1, 64'h10,  1'b0, 1'b0, 4, 1'b1, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 64'h0,   1'b0, 1'b1, 3, 1'b1, 1'b1, 64'h4};
        vecs[6]  = '{1'b0, 64'h0,   1'b0, 1'b1, 2, 1'b1, 1'b1, 64'h8};
        vecs[7]  = '{1'b1, 64'h10,  1'b0, 1'b1, 2, 1'b1, 1'b1, 64'hC};
        vecs[8]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1, 1'b1, 1'b1, 64'h10};
        vecs[9]  = '{1'b0, 64'h0,   1'b0, 1'b1, 0, 1'b0, 1'b1, 64'h0};
        vecs[10] = '{1'b1, 64'h20,  1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h20};
        vecs[11] = '{1'b1, 64'h24,  1'b0, 1'b0, 2, 1'b1, 1'b1, 64'h20};
        vecs[12] = '{1'b1, 64'h28,  1'b1, 1'b1, 0, 1'b0, 1'b1, 64'h0};
        vecs[13] = '{1'b1, 64'h100, 1'b0, 1'b0, 1, 1'b1, 1'b1, 64'h100};
        vecs[14] = '{1'b0, 64'h0,   1'b0, 1'b1, 0, 1'b0, 1'b1, 64'h0};
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].vf, vecs[i].pc, instr_of(vecs[i].pc),
                          vecs[i].fl, vecs[i].rd, $sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.post_count", i), N'(count),   N'(vecs[i].exp_count));
            cmp($sformatf("vec%0d.post_valid", i), N'(valid_D), N'(vecs[i].exp_valid));
            cmp($sformatf("vec%0d.post_ready", i), N'(ready_F), N'(vecs[i].exp_ready));
            cmp($sformatf("vec%0d.post_pc", i),    pc_D,        vecs[i].exp_pc);
        end

        // Streaming: 16 entries at full throughput, occupancy holds at 1.
        seen_pc.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, N'(i * 4), instr_of(N'(i * 4)), 1'b0, 1'b1, "stream");
            cmp("stream.count", N'(count), N'(1));
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, "stream_drain");
        cmp("stream.num_seen", N'(seen_pc.size()), N'(16));
        for (int i = 0; i < 16 && i < seen_pc.size(); i++) begin
            cmp($sformatf("stream.order%0d", i), seen_pc[i], N'(i * 4));
        end

        // Wrap-around from pointer 0: push 3, pop 3, push 4, then drain.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, "wrap_flush");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, N'(64'h200 + i * 4), instr_of(N'(64'h200 + i * 4)), 1'b0, 1'b0, "wrap_push3");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, "wrap_pop3");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, N'(64'h300 + i * 4), instr_of(N'(64'h300 + i * 4)), 1'b0, 1'b0, "wrap_push4");
        cmp("wrap.count", N'(count), N'(4));
        cmp("wrap.wr_ptr", N'(dut.wr_ptr), N'(3));
        seen_pc.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, "wrap_drain");
        for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
            cmp($sformatf("wrap.order%0d", i), seen_pc[i], N'(64'h300 + i * 4));
        end

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, N'(64'h400 + i * 4), instr_of(N'(64'h400 + i * 4)), 1'b0, 1'b0, "ar_fill");
        cmp("ar.pre_count", N'(count), N'(3));
        valid_F = 1'b0;
        ready_D = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_q.delete();
        cmp("ar.count",   N'(count),   '0);
        cmp("ar.valid_D", N'(valid_D), '0);
        cmp("ar.pc_D",    pc_D,        '0);
        cmp("ar.instr_D", N'(instr_D), '0);
        @(posedge clk);
        #1;
        idle(2, "ar_idle");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          {32'h0, $urandom} & 64'hFFFF_FFFC | 64'(i) << 32,
                          $urandom,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 2) != 0,
                          "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

- Instruction buffer between the fetch stage (PC register plus instruction memory) and decode.
- Captures fetched `(pc, instruction)` pairs into a small circular FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures fetch when full, so fetch holds its PC.
- Discards all buffered instructions when fetch redirects on a taken branch (`PCSrc_F`).

## Interface
- `N`, default 64: PC width in bits.
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `valid_F`  in  1: fetch offers an entry this cycle.
- `pc_F`  in  N: PC of the offered instruction.
- `instr_F`  in  32: instruction word read from imem at `pc_F`.
- `flush_F`  in  1: taken-branch redirect; tie to `PCSrc_F`.
- `ready_F`  out  1: buffer accepts an entry this cycle; fetch uses it as PC enable.
- `valid_D`  out  1: head entry available to decode.
- `pc_D`  out  N: PC of head entry.
- `instr_D`  out  32: instruction of head entry.
- `ready_D`  in  1: decode consumes the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
**Storage**
- `DEPTH` entries of `{pc, instr}`.
- Read pointer `rd_ptr` and write pointer `wr_ptr`, each $clog2(DEPTH) bits, wrapping modulo `DEPTH`.
- `count` is held in a register, not derived from the pointers, so full and empty are unambiguous.

**Handshake**
- `push` = `valid_F & ready_F & ~flush_F`.
- `pop` = `valid_D & ready_D & ~flush_F`.
- `ready_F` = (`count` != `DEPTH`). There is no pass-through when full: a pop in the same cycle does not raise `ready_F`.
- `valid_D` = (`count` != 0).
- `pc_D`/`instr_D` = entry at `rd_ptr` when `valid_D` is 1; forced to all-zero when empty.

**Occupancy state**, decoded from `count`:
- EMPTY: `count` = 0.
- PARTIAL: 0 < `count` < `DEPTH`.
- FULL: `count` = `DEPTH`.

**Transitions at the clock edge**
- `push` only: write entry, `wr_ptr`+1, `count`+1. EMPTY→PARTIAL, or PARTIAL→FULL when `count` reaches `DEPTH`.
- `pop` only: `rd_ptr`+1, `count`−1. FULL→PARTIAL, or PARTIAL→EMPTY when `count` reaches 0.
- `push` and `pop` together: both pointers advance, `count` unchanged. This is only possible in PARTIAL.
- `flush_F`: `rd_ptr` = `wr_ptr` = 0 and `count` = 0, from any state. A push or pop in the same cycle is suppressed.

**Boundary rules**
- Pop when empty: impossible, because `valid_D` = 0.
- Push when full: ignored; `ready_F` = 0 is the fetch's stall signal.
- Pointer wrap from `DEPTH`−1 to 0 is seamless; entry order is preserved across the wrap.
- `reset` asserted mid-operation: all state clears immediately, asynchronously, regardless of `clk`.

## Timing
- Reset values: `count` = 0, `valid_D` = 0, `pc_D` = 0, `instr_D` = 0, `ready_F` = 1, both pointers 0. Storage array contents are don't-care.
- Latency: an entry pushed at edge k is visible on `valid_D`/`pc_D`/`instr_D` after edge k (one cycle), even when the buffer was empty. There is no combinational input→output path.
- Throughput: one push and one pop per cycle in PARTIAL.
- `ready_F` and `valid_D` depend only on registered `count`. No combinational path exists from `ready_D` to `ready_F`, nor from `valid_F` to `valid_D`.
- Flush takes effect at the edge where `flush_F` = 1. The next cycle shows `valid_D` = 0 and `ready_F` = 1. The first post-branch instruction (PC = branch target) can be pushed in that next cycle.
- Writes occur on the rising edge only. Reads of the head are combinational from registered storage.

## Structure
- Shared package `fetch_pkg` contains:
  - `INSTR_W` = 32.
  - Default `FB_DEPTH` = 4.
  - `typedef struct packed { logic [N-1:0] pc; logic [INSTR_W-1:0] instr; } fetch_entry_t`, with N fixed at 64 in the package.
- One sub-module is natural: `fb_ram`, a `DEPTH`×entry register array with a synchronous write port and an asynchronous read port, no reset.
- Pointer, `count` and handshake logic live in `fetch_buffer`.

## Test plan
- Reset then idle: after `reset` deasserts, `count` = 0, `valid_D` = 0, `ready_F` = 1, `pc_D` = 0; stays so with `valid_F` = 0 for 5 cycles.
- Fill to full: push PCs 0x0, 0x4, 0x8, 0xC with `ready_D` = 0 → `count` = 4 and `ready_F` = 0. A fifth push of PC 0x10 is ignored, and `pc_D` stays 0x0.
- Streaming: `valid_F` = 1 and `ready_D` = 1 continuously for PCs 0x0..0x3C → decode sees 16 entries in order with one-cycle latency, and `count` stays 1.
- Wrap-around: push 3, pop 3, then push 4 → outputs in order, `wr_ptr` wraps to 0, and `count` = 4 at the end.
- Flush with simultaneous push/pop: with `count` = 2 (PCs 0x20, 0x24), assert `flush_F` together with a push of 0x28 and `ready_D` = 1 → next cycle `count` = 0 and `valid_D` = 0. Then a push of branch target 0x100 gives `pc_D` = 0x100 one cycle later.
- Async reset mid-fill: with `count` = 3, pulse `reset` between clock edges → `count`, `valid_D`, `pc_D` and `instr_D` drop to 0 before the next rising edge.
